// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes and the
// memory-stage FSM state type.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StHalted
   } state_t;

   // Instructions that read a quad from data memory.
   function automatic logic is_mem_read(input logic [3:0] icode);
      return (icode == IMRMOVQ) || (icode == IRET) || (icode == IPOPQ);
   endfunction

   // Instructions that write a quad to data memory.
   function automatic logic is_mem_write(input logic [3:0] icode);
      return (icode == IRMMOVQ) || (icode == ICALL) || (icode == IPUSHQ);
   endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Request/response bundle between the execute side and the memory stage.
interface memory_stage_if;

   logic        start;
   logic [3:0]  icode;
   logic        instr_valid;
   logic        imem_error;
   logic [63:0] valE;
   logic [63:0] valA;
   logic [63:0] valP;
   logic        busy;
   logic        done;
   logic [63:0] valM;
   logic [2:0]  stat;

   modport master (
      output start, icode, instr_valid, imem_error, valE, valA, valP,
      input  busy, done, valM, stat
   );

   modport slave (
      input  start, icode, instr_valid, imem_error, valE, valA, valP,
      output busy, done, valM, stat
   );

endinterface

// File: rtl/data_memory.sv
// Byte-addressable data memory: one registered 8-byte little-endian write
// port and one combinational 8-byte read port. Contents are never reset.
module data_memory #(
   parameter int unsigned MEM_BYTES = 1024,
   parameter int unsigned AW        = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [63:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [63:0]   rdata
);

   logic [7:0] mem [0:MEM_BYTES-1];

   // Commit all eight bytes of a quad write on the clock edge.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 8; i++) begin
            mem[waddr + AW'(i)] <= wdata[8*i +: 8];
         end
      end
   end

   // Assemble the quad starting at raddr; byte raddr lands in bits 7:0.
   always_comb begin
      rdata = '0;
      for (int i = 0; i < 8; i++) begin
         rdata[8*i +: 8] = mem[raddr + AW'(i)];
      end
   end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 SEQ memory stage: accepts one request over start/busy/done, performs
// the data-memory access one edge later and reports valM and a sticky stat.
// Optional build macro: MEM_ALIGN_CHECK_EN makes any quad access with
// addr[2:0] != 0 an address error instead of a bytewise access.
module memory_stage
   import y86_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 1024
) (
   input logic           clk,
   input logic           rst,
   memory_stage_if.slave bus
);

   localparam int unsigned AW       = $clog2(MEM_BYTES);
   localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES) - 64'd8;

   state_t      state_q, state_d;
   logic [3:0]  icode_q;
   logic [63:0] vale_q, vala_q, valp_q;
   logic        instr_valid_q, imem_error_q;
   logic [63:0] valm_q;
   logic [2:0]  stat_q;
   logic        done_q;

   logic        accept, in_access;
   logic        rd, wr, dmem_error, we;
   logic [63:0] addr, wdata, rdata;
   logic [2:0]  stat_new;

   assign accept    = (state_q == StIdle) && bus.start;
   assign in_access = (state_q == StAccess);

   // Decode the latched request: address source, write data, error and status.
   always_comb begin
      rd    = is_mem_read(icode_q);
      wr    = is_mem_write(icode_q);
      addr  = ((icode_q == IRET) || (icode_q == IPOPQ)) ? vala_q : vale_q;
      wdata = (icode_q == ICALL) ? valp_q : vala_q;
`ifdef MEM_ALIGN_CHECK_EN
      dmem_error = (rd || wr) && ((addr > MAX_ADDR) || (addr[2:0] != 3'b000));
`else
      dmem_error = (rd || wr) && (addr > MAX_ADDR);
`endif
      if (imem_error_q || dmem_error) begin
         stat_new = SADR;
      end else if (!instr_valid_q) begin
         stat_new = SINS;
      end else if (icode_q == IHALT) begin
         stat_new = SHLT;
      end else begin
         stat_new = SAOK;
      end
      we = in_access && wr && !dmem_error;
   end

   // Next-state logic: one access cycle, then idle or halt on a bad status.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (bus.start) state_d = StAccess;
         StAccess: state_d = (stat_new == SAOK) ? StIdle : StHalted;
         StHalted: state_d = StHalted;
         default:  state_d = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture the request fields when a start is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         icode_q       <= IHALT;
         vale_q        <= '0;
         vala_q        <= '0;
         valp_q        <= '0;
         instr_valid_q <= 1'b0;
         imem_error_q  <= 1'b0;
      end else if (accept) begin
         icode_q       <= bus.icode;
         vale_q        <= bus.valE;
         vala_q        <= bus.valA;
         valp_q        <= bus.valP;
         instr_valid_q <= bus.instr_valid;
         imem_error_q  <= bus.imem_error;
      end
   end

   // Result registers: done pulses for the access cycle, stat is sticky once halted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valm_q <= '0;
         stat_q <= SAOK;
         done_q <= 1'b0;
      end else begin
         done_q <= in_access;
         if (in_access) begin
            stat_q <= stat_new;
            if (rd && !dmem_error) begin
               valm_q <= rdata;
            end
         end
      end
   end

   // Addresses past MAX_ADDR never reach the array, so truncation is safe.
   data_memory #(
      .MEM_BYTES (MEM_BYTES),
      .AW        (AW)
   ) u_dmem (
      .clk   (clk),
      .we    (we),
      .waddr (addr[AW-1:0]),
      .wdata (wdata),
      .raddr (addr[AW-1:0]),
      .rdata (rdata)
   );

   assign bus.busy = in_access;
   assign bus.done = done_q;
   assign bus.valM = valm_q;
   assign bus.stat = stat_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus a randomized request stream,
// checked against a byte-array reference model of the memory stage.
// Honours MEM_ALIGN_CHECK_EN in the reference model when the macro is defined.
module tb_memory_stage;
   import y86_pkg::*;

   localparam int unsigned MEM_BYTES = 1024;

   logic clk = 1'b0;
   logic rst = 1'b1;

   memory_stage_if bus ();

   memory_stage #(
      .MEM_BYTES (MEM_BYTES)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   byte unsigned ref_mem [MEM_BYTES];
   logic [63:0]  ref_valm;
   logic [2:0]   ref_stat;
   bit           ref_halted;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] dut_quad(input int unsigned a);
      logic [63:0] q = '0;
      for (int i = 0; i < 8; i++) q[8*i +: 8] = dut.u_dmem.mem[a + i];
      return q;
   endfunction

   function automatic logic [63:0] ref_quad(input int unsigned a);
      logic [63:0] q = '0;
      for (int i = 0; i < 8; i++) q = q | (64'(ref_mem[a + i]) << (8 * i));
      return q;
   endfunction

   function automatic int mem_diffs();
      int n = 0;
      for (int i = 0; i < MEM_BYTES; i++) if (dut.u_dmem.mem[i] !== ref_mem[i]) n++;
      return n;
   endfunction

   // Reference behaviour of one completed request.
   task automatic model_req(input logic [3:0] ic, input logic [63:0] e, a, p,
                            input logic iv, ie);
      bit          rd = ic inside {4'h5, 4'h9, 4'hB};
      bit          wr = ic inside {4'h4, 4'h8, 4'hA};
      logic [63:0] ad = (ic == 4'h9 || ic == 4'hB) ? a : e;
      logic [63:0] data = (ic == 4'h8) ? p : a;
      bit          err = (rd || wr) && (ad > 64'(MEM_BYTES) - 64'd8);
`ifdef MEM_ALIGN_CHECK_EN
      if ((rd || wr) && (ad % 8 != 0)) err = 1'b1;
`endif
      if (ie || err)  ref_stat = 3'd3;
      else if (!iv)   ref_stat = 3'd4;
      else if (ic == 4'h0) ref_stat = 3'd2;
      else            ref_stat = 3'd1;
      if (!err && wr) for (int i = 0; i < 8; i++) ref_mem[int'(ad) + i] = byte'(data >> (8 * i));
      if (!err && rd) ref_valm = ref_quad(int'(ad));
      if (ref_stat != 3'd1) ref_halted = 1'b1;
   endtask

   // Issue one request now (off-edge) and check it through completion.
   task automatic do_req(input string tag, input logic [3:0] ic, input logic [63:0] e, a, p,
                         input logic iv = 1'b1, input logic ie = 1'b0);
      bus.start = 1'b1; bus.icode = ic; bus.valE = e; bus.valA = a; bus.valP = p;
      bus.instr_valid = iv; bus.imem_error = ie;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (ref_halted) begin
         chk({tag, "_halt_busy"}, bus.busy, 0);
         chk({tag, "_halt_done"}, bus.done, 0);
         @(posedge clk); #1;
         chk({tag, "_halt_done2"}, bus.done, 0);
         chk({tag, "_halt_stat"}, bus.stat, ref_stat);
         return;
      end
      chk({tag, "_busy"}, bus.busy, 1);
      chk({tag, "_done_early"}, bus.done, 0);
      @(posedge clk); #1;
      model_req(ic, e, a, p, iv, ie);
      chk({tag, "_done"}, bus.done, 1);
      chk({tag, "_busy_end"}, bus.busy, 0);
      chk({tag, "_valM"}, bus.valM, ref_valm);
      chk({tag, "_stat"}, bus.stat, ref_stat);
   endtask

   // One quiet cycle: the done pulse must already be gone.
   task automatic idle_chk(input string tag);
      @(posedge clk); #1;
      chk({tag, "_done_width"}, bus.done, 0);
      chk({tag, "_busy_idle"}, bus.busy, 0);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      ref_valm = '0; ref_stat = 3'd1; ref_halted = 1'b0;
      chk({tag, "_rst_busy"}, bus.busy, 0);
      chk({tag, "_rst_done"}, bus.done, 0);
      chk({tag, "_rst_valM"}, bus.valM, ref_valm);
      chk({tag, "_rst_stat"}, bus.stat, ref_stat);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0]  ic;
      logic [63:0] ad, e, a;

      bus.start = 1'b0; bus.icode = '0; bus.valE = '0; bus.valA = '0; bus.valP = '0;
      bus.instr_valid = 1'b1; bus.imem_error = 1'b0;
      for (int i = 0; i < MEM_BYTES; i++) begin
         ref_mem[i] = byte'($urandom);
         dut.u_dmem.mem[i] = ref_mem[i];
      end
      repeat (2) @(posedge clk);
      do_reset("init");

      // Write then read back, back-to-back.
      do_req("t1_wr", IRMMOVQ, 64'h40, 64'hDEADBEEF, 64'($urandom));
      do_req("t1_rd", IMRMOVQ, 64'h40, 64'($urandom), 64'($urandom));
      idle_chk("t1");
      chk("t1_valM_const", bus.valM, 64'hDEADBEEF);

      // Non-memory icode: valM and memory untouched.
      do_req("t3", IOPQ, 64'd7, 64'($urandom), 64'($urandom));
      idle_chk("t3");
      chk("t3_valM_hold", bus.valM, 64'hDEADBEEF);
      chk("t3_mem", mem_diffs(), 0);

      // push/pop and call/ret address and data sources.
      do_req("t2_push", IPUSHQ, 64'h100, 64'd19, 64'($urandom));
      idle_chk("t2a");
      do_req("t2_pop", IPOPQ, 64'($urandom), 64'h100, 64'($urandom));
      chk("t2_pop_const", bus.valM, 64'd19);
      do_req("t2_call", ICALL, 64'h80, 64'($urandom), 64'h2A);
      do_req("t2_ret", IRET, 64'($urandom), 64'h80, 64'($urandom));
      chk("t2_ret_const", bus.valM, 64'h2A);
      idle_chk("t2b");

      // Unaligned read.
      do_req("unal", IMRMOVQ, 64'h41, 64'($urandom), 64'($urandom));
`ifdef MEM_ALIGN_CHECK_EN
      chk("unal_stat_const", bus.stat, 3'd3);
`else
      chk("unal_stat_const", bus.stat, 3'd1);
`endif
      idle_chk("unal");
      do_reset("unal");

      // Random request stream over a small address pool.
      for (int n = 0; n < 60; n++) begin
         ic = 4'($urandom_range(1, 11));
         ad = 64'h200 + 64'($urandom_range(0, 15)) * 8;
         e  = {$urandom, $urandom};
         a  = {$urandom, $urandom};
         if (ic == IRET || ic == IPOPQ) a = ad; else e = ad;
         do_req("rnd", ic, e, a, {$urandom, $urandom});
         if ($urandom_range(0, 1) == 1) idle_chk("rnd");
      end
      idle_chk("rnd_end");
      chk("rnd_mem", mem_diffs(), 0);

      // Out-of-range write: ADR, no write, then halted ignores start.
      do_req("t4", IRMMOVQ, 64'(MEM_BYTES - 4), {$urandom, $urandom}, 64'($urandom));
      chk("t4_stat_const", bus.stat, 3'd3);
      idle_chk("t4");
      do_req("t4_ign", IMRMOVQ, 64'h40, 64'($urandom), 64'($urandom));
      chk("t4_mem", mem_diffs(), 0);
      chk("t4_tail", dut_quad(MEM_BYTES - 8), ref_quad(MEM_BYTES - 8));

      // Status priority.
      do_reset("t5a");
      do_req("t5_hlt", IHALT, 64'($urandom), 64'($urandom), 64'($urandom));
      chk("t5_hlt_const", bus.stat, 3'd2);
      do_reset("t5b");
      do_req("t5_ins", IOPQ, 64'($urandom), 64'($urandom), 64'($urandom), 1'b0, 1'b0);
      chk("t5_ins_const", bus.stat, 3'd4);
      do_reset("t5c");
      do_req("t5_adr", IOPQ, 64'($urandom), 64'($urandom), 64'($urandom), 1'b0, 1'b1);
      chk("t5_adr_const", bus.stat, 3'd3);
      do_reset("t5d");

      // Reset while busy drops the pending write.
      bus.start = 1'b1; bus.icode = IRMMOVQ; bus.valE = 64'h20; bus.valA = 64'd5;
      bus.instr_valid = 1'b1; bus.imem_error = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("t6_busy", bus.busy, 1);
      #2;
      do_reset("t6");
      chk("t6_mem20", dut_quad(32'h20), ref_quad(32'h20));
      chk("t6_mem", mem_diffs(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
